relu_bank_seq: RTL and testbench
================================

Name: relu_bank_seq

Overview:
Sequencer for the 16-lane ReLU bank (relu_4n: 4 neurons x 4 inputs, W-bit signed). It collects four 4-lane vectors from the upstream accumulator stream and fires the bank once. It waits for the bank's ready flag and captures the 16 results. It then drains them downstream one neuron-vector per beat. A watchdog flags a bank that never reports ready.

Parameters:
W, 21, signed data width per lane (matches the bank's size parameter)
TIMEOUT, 64, max cycles in WAIT before error (>=2)
FCNT_W, 16, width of the completed-frame counter

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous active-low reset
s_valid  in  1  upstream vector valid
s_ready  out  1  controller accepts upstream vector
s_data  in  4*W  lane i at [i*W +: W], one neuron's 4 inputs
relu_go  out  1  one-cycle start pulse to bank in_ready
relu_in  out  16*W  bank operands; index n*4+i = neuron n, input i, at [(n*4+i)*W +: W]
relu_done  in  1  bank relu_ready
relu_out  in  16*W  bank results, same packing as relu_in
m_valid  out  1  downstream vector valid
m_ready  in  1  downstream accepts
m_data  out  4*W  one neuron's 4 results, lane packing as s_data
m_last  out  1  high with the 4th (neuron 3) drain beat
busy  out  1  state != FILL
err  out  1  sticky watchdog error
clr_err  in  1  clears ERR state
frames_done  out  FCNT_W  count of fully drained frames

Behaviour:
- Reset (rst_n=0 at an edge): state=FILL; fill_cnt, drain_cnt, timer, frames_done=0; stage/result regs=0. While rst_n=0: s_ready, relu_go, m_valid, m_last, busy, err all 0. Reset mid-operation discards all partial data.
- FSM states: FILL, FIRE, WAIT, DRAIN, ERR.
- FILL: s_ready=1. On s_valid&s_ready, stage[fill_cnt] <= s_data and fill_cnt++. The handshake at fill_cnt=3 goes to FIRE and sets fill_cnt=0.
- FIRE: exactly one cycle with relu_go=1, s_ready=0. Next state WAIT; timer <= 0.
- relu_in is driven from stage regs continuously. It is stable from FIRE through the end of WAIT and changes only on FILL handshakes.
- WAIT: relu_done is sampled only here (WAIT starts the cycle after relu_go). relu_done=1 captures relu_out into result regs, sets drain_cnt=0, and goes to DRAIN. Otherwise timer++.
- Watchdog: when timer==TIMEOUT-1 and relu_done=0, go to ERR. If relu_done=1 on that same cycle, done wins.
- relu_done in FILL, FIRE, DRAIN or ERR is ignored.
- DRAIN: m_valid=1, m_data=result[drain_cnt], m_last=(drain_cnt==3). m_data and m_last hold stable while m_valid&!m_ready. On m_valid&m_ready, drain_cnt++.
- The handshake at drain_cnt=3 goes to FILL and frames_done++ (wraps modulo 2^FCNT_W). s_ready is 0 throughout DRAIN; there is no fill/drain overlap.
- ERR: err=1, s_ready=0, m_valid=0, relu_go=0. Only clr_err=1 or reset exits. clr_err goes to FILL with fill_cnt, timer and err cleared; frames_done is retained. clr_err outside ERR is ignored.
- busy=1 in FIRE, WAIT, DRAIN, ERR.
- Latency: with s_valid held high, handshakes occur at cycles 0-3 and relu_go=1 at cycle 4. If relu_done first rises at cycle 4+L (L>=1), m_valid=1 at cycle 5+L. With m_ready held high, m_last occurs at cycle 8+L and s_ready returns at cycle 9+L.
- The controller does no arithmetic on data; values pass bit-exact.

Test Plan:
- Basic frame: feed s_data lanes {-5,3,0,-1},{7,-2,4,9},{-8,-8,1,2},{0,0,-3,6}; bank model returns max(x,0) with L=2 -> one relu_go pulse at cycle 4. m_data beats are {0,3,0,0},{7,0,4,9},{0,0,1,2},{0,0,0,6}; m_last only on beat 4; frames_done=1.
- Upstream and downstream stalls: s_valid toggles 1/0 and m_ready low for 3 cycles on beat 2 -> still exactly 4 accepted and 4 emitted beats. m_data is held stable during the stall. relu_in stays constant from FIRE to capture.
- Watchdog: bank never asserts done with TIMEOUT=64 -> ERR entered 64 cycles after WAIT starts, err=1, s_ready=0. A clr_err pulse returns to FILL with err=0 and frames_done unchanged.
- Timeout boundary: relu_done rises exactly on timer==63 -> DRAIN entered, err stays 0.
- Spurious done: relu_done=1 during FILL and DRAIN -> no capture, no state change.
- Reset mid-WAIT: rst_n=0 for 1 cycle -> all outputs 0. The next frame requires 4 fresh s handshakes before relu_go. frames_done=0.

Source files
------------

// File: rtl/relu_bank_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : relu_bank_seq_if
// Brief    : Upstream vector stream and downstream result stream of the
//            ReLU bank sequencer.
// Revision : 1.0
// ============================================================================
interface relu_bank_seq_if #(
    parameter int W = 21
);
    logic           s_valid;
    logic           s_ready;
    logic [4*W-1:0] s_data;
    logic           m_valid;
    logic           m_ready;
    logic [4*W-1:0] m_data;
    logic           m_last;

    // Environment side: produces upstream vectors, consumes drained results
    modport master (
        output s_valid,
        output s_data,
        input  s_ready,
        input  m_valid,
        input  m_data,
        input  m_last,
        output m_ready
    );

    // Sequencer side
    modport slave (
        input  s_valid,
        input  s_data,
        output s_ready,
        output m_valid,
        output m_data,
        output m_last,
        input  m_ready
    );
endinterface
`default_nettype wire

// File: rtl/relu_bank_seq.sv
`default_nettype none
// ============================================================================
// Module   : relu_bank_seq
// Brief    : Collects four neuron vectors, fires the 16-lane ReLU bank once,
//            captures its results and drains them one neuron per beat.
// Revision : 1.0
// ============================================================================
module relu_bank_seq #(
    parameter int W       = 21,
    parameter int TIMEOUT = 64,
    parameter int FCNT_W  = 16
) (
    input  wire                clk,
    input  wire                rst_n,
    relu_bank_seq_if.slave     bus,
    output logic               relu_go,
    output logic [16*W-1:0]    relu_in,
    input  wire                relu_done,
    input  wire  [16*W-1:0]    relu_out,
    output logic               busy,
    output logic               err,
    input  wire                clr_err,
    output logic [FCNT_W-1:0]  frames_done
);

    localparam int c_TMR_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_TMR_W-1:0] c_TMR_LAST = c_TMR_W'(TIMEOUT - 1);
    localparam int c_VEC_W = 4 * W;

    typedef enum logic [2:0] {
        S_FILL  = 3'd0,
        S_FIRE  = 3'd1,
        S_WAIT  = 3'd2,
        S_DRAIN = 3'd3,
        S_ERR   = 3'd4
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic [1:0]            r_fill_cnt;
    logic [1:0]            r_drain_cnt;
    logic [c_TMR_W-1:0]    r_timer;
    logic [FCNT_W-1:0]     r_frames;
    logic [c_VEC_W-1:0]    r_stage  [4];
    logic [c_VEC_W-1:0]    r_result [4];

    logic                  w_s_ready;
    logic                  w_relu_go;
    logic                  w_m_valid;
    logic                  w_busy;
    logic                  w_err;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_FILL;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and control outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        w_s_ready    = 1'b0;
        w_relu_go    = 1'b0;
        w_m_valid    = 1'b0;
        w_busy       = 1'b1;
        w_err        = 1'b0;
        case (r_state)
            S_FILL: begin
                w_s_ready = 1'b1;
                w_busy    = 1'b0;
                if (bus.s_valid && (r_fill_cnt == 2'd3)) begin
                    w_next_state = S_FIRE;
                end
            end
            S_FIRE: begin
                w_relu_go    = 1'b1;
                w_next_state = S_WAIT;
            end
            S_WAIT: begin
                // A done arriving on the last watchdog cycle still wins
                if (relu_done) begin
                    w_next_state = S_DRAIN;
                end else if (r_timer == c_TMR_LAST) begin
                    w_next_state = S_ERR;
                end
            end
            S_DRAIN: begin
                w_m_valid = 1'b1;
                if (bus.m_ready && (r_drain_cnt == 2'd3)) begin
                    w_next_state = S_FILL;
                end
            end
            S_ERR: begin
                w_err = 1'b1;
                if (clr_err) begin
                    w_next_state = S_FILL;
                end
            end
            default: begin
                w_next_state = S_FILL;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Counters, staging and result registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_fill_cnt  <= 2'd0;
            r_drain_cnt <= 2'd0;
            r_timer     <= '0;
            r_frames    <= '0;
            for (int n = 0; n < 4; n++) begin
                r_stage[n]  <= '0;
                r_result[n] <= '0;
            end
        end else begin
            case (r_state)
                S_FILL: begin
                    if (bus.s_valid) begin
                        r_stage[r_fill_cnt] <= bus.s_data;
                        r_fill_cnt          <= r_fill_cnt + 2'd1;
                    end
                end
                S_FIRE: begin
                    r_timer <= '0;
                end
                S_WAIT: begin
                    if (relu_done) begin
                        for (int n = 0; n < 4; n++) begin
                            r_result[n] <= relu_out[n*c_VEC_W +: c_VEC_W];
                        end
                        r_drain_cnt <= 2'd0;
                    end else begin
                        r_timer <= r_timer + c_TMR_W'(1);
                    end
                end
                S_DRAIN: begin
                    if (bus.m_ready) begin
                        r_drain_cnt <= r_drain_cnt + 2'd1;
                        if (r_drain_cnt == 2'd3) begin
                            r_frames <= r_frames + FCNT_W'(1);
                        end
                    end
                end
                S_ERR: begin
                    if (clr_err) begin
                        r_fill_cnt <= 2'd0;
                        r_timer    <= '0;
                    end
                end
                default: begin
                    r_fill_cnt <= 2'd0;
                end
            endcase
        end
    end

    // Bank operands come straight from the staging registers
    for (genvar n = 0; n < 4; n++) begin : g_neuron
        assign relu_in[n*c_VEC_W +: c_VEC_W] = r_stage[n];
    end

    // Control outputs are forced low while reset is held
    assign bus.s_ready  = rst_n & w_s_ready;
    assign relu_go      = rst_n & w_relu_go;
    assign bus.m_valid  = rst_n & w_m_valid;
    assign bus.m_last   = rst_n & w_m_valid & (r_drain_cnt == 2'd3);
    assign bus.m_data   = r_result[r_drain_cnt];
    assign busy         = rst_n & w_busy;
    assign err          = rst_n & w_err;
    assign frames_done  = r_frames;

endmodule
`default_nettype wire

// File: tb/tb_relu_bank_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_relu_bank_seq
// Brief    : Self-checking bench for relu_bank_seq with a behavioural bank.
// Revision : 1.0
// ============================================================================
module tb_relu_bank_seq;
    localparam int W       = 21;
    localparam int TIMEOUT = 64;
    localparam int FCNT_W  = 16;
    localparam int VW      = 4 * W;
    localparam int BUDGET  = 400;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               relu_go;
    logic [16*W-1:0]    relu_in;
    logic               relu_done;
    logic [16*W-1:0]    relu_out;
    logic               busy;
    logic               err;
    logic               clr_err;
    logic [FCNT_W-1:0]  frames_done;

    relu_bank_seq_if #(.W(W)) bus ();

    relu_bank_seq #(.W(W), .TIMEOUT(TIMEOUT), .FCNT_W(FCNT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .relu_go     (relu_go),
        .relu_in     (relu_in),
        .relu_done   (relu_done),
        .relu_out    (relu_out),
        .busy        (busy),
        .err         (err),
        .clr_err     (clr_err),
        .frames_done (frames_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [FCNT_W-1:0] frames_model = '0;

    typedef struct {
        logic [16*W-1:0] din;
        logic [16*W-1:0] dexp;
        int              lat;
        bit              toggle;
        int              stall_beat;
        int              stall_len;
        bit              chk_lat;
    } vec_t;
    vec_t tbl [3];

    // Per-frame observations
    logic [VW-1:0]    f_in  [4];
    logic [VW-1:0]    f_got [4];
    logic [16*W-1:0]  f_snap;
    int f_go, f_mv, f_last, f_sready, f_err, f_gocnt, f_sent;
    bit f_stable, f_mhold, f_lastok, f_extra, f_budget;

    task automatic chk(input string name, input logic [16*W-1:0] act, input logic [16*W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [VW-1:0] pk4(input int a, input int b, input int c, input int d);
        logic [W-1:0] t0, t1, t2, t3;
        t0 = W'(a); t1 = W'(b); t2 = W'(c); t3 = W'(d);
        return {t3, t2, t1, t0};
    endfunction

    // Reference ReLU on one 4-lane vector
    function automatic logic [VW-1:0] relu4(input logic [VW-1:0] v);
        logic [VW-1:0] r;
        for (int k = 0; k < 4; k++) begin
            r[k*W +: W] = ($signed(v[k*W +: W]) < 0) ? '0 : v[k*W +: W];
        end
        return r;
    endfunction

    function automatic logic [16*W-1:0] relu16(input logic [16*W-1:0] v);
        logic [16*W-1:0] r;
        for (int n = 0; n < 4; n++) r[n*VW +: VW] = relu4(v[n*VW +: VW]);
        return r;
    endfunction

    // One frame, cycle by cycle at the falling edge; lat<0 means the bank never answers
    task automatic run_frame(input int lat, input bit toggle, input int stall_beat,
                             input int stall_len, input bit spur, input int stop_after_go);
        int got, stall_cnt, cyc;
        logic [VW-1:0] held;
        logic held_last;
        f_go = -1; f_mv = -1; f_last = -1; f_sready = -1; f_err = -1;
        f_gocnt = 0; f_sent = 0; got = 0; stall_cnt = 0;
        f_stable = 1; f_mhold = 1; f_lastok = 1; f_extra = 0; f_budget = 1;
        held = '0; held_last = 1'b0; f_snap = '0;
        for (cyc = 0; cyc < BUDGET; cyc++) begin
            @(negedge clk);
            if (relu_go) begin
                f_gocnt++;
                if (f_go < 0) begin f_go = cyc; f_snap = relu_in; end
            end else if (f_go >= 0 && f_mv < 0 && relu_in !== f_snap) begin
                f_stable = 0;
            end
            if (bus.m_valid && f_mv < 0) f_mv = cyc;
            if (err && f_err < 0) f_err = cyc;
            if (got == 4 && bus.s_ready) begin f_sready = cyc; f_budget = 0; break; end
            if (f_err >= 0) begin f_budget = 0; break; end
            if (stop_after_go >= 0 && f_go >= 0 && cyc >= f_go + stop_after_go) begin
                f_budget = 0; break;
            end
            // upstream source
            bus.s_valid = (f_sent < 4) && (!toggle || (cyc % 2 == 0));
            bus.s_data  = (f_sent < 4) ? f_in[f_sent] : '0;
            if (bus.s_valid && bus.s_ready) f_sent++;
            // behavioural bank
            if (spur && f_go < 0) begin
                relu_done = 1'b1;
                relu_out  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
                             $urandom, $urandom, $urandom, $urandom, $urandom};
            end else if (f_go >= 0 && lat >= 0 && cyc >= f_go + lat && f_mv < 0) begin
                relu_done = 1'b1;
                relu_out  = relu16(f_snap);
            end else if (spur && f_mv >= 0) begin
                relu_done = 1'b1;
                relu_out  = ~relu16(f_snap);
            end else begin
                relu_done = 1'b0;
            end
            // downstream sink
            bus.m_ready = 1'b1;
            if (bus.m_valid) begin
                if (got >= 4) begin
                    f_extra = 1;
                end else if (got == stall_beat && stall_cnt < stall_len) begin
                    if (stall_cnt == 0) begin
                        held = bus.m_data; held_last = bus.m_last;
                    end else if (bus.m_data !== held || bus.m_last !== held_last) begin
                        f_mhold = 0;
                    end
                    bus.m_ready = 1'b0;
                    stall_cnt++;
                end else begin
                    if (got == stall_beat && stall_cnt > 0 && bus.m_data !== held) f_mhold = 0;
                    f_got[got] = bus.m_data;
                    if (bus.m_last !== (got == 3)) f_lastok = 0;
                    if (got == 3) f_last = cyc;
                    got++;
                end
            end else if (bus.m_last) begin
                f_lastok = 0;
            end
        end
        bus.s_valid = 1'b0;
        relu_done   = 1'b0;
        bus.m_ready = 1'b1;
    endtask

    task automatic check_frame(input logic [16*W-1:0] exp, input int lat, input bit chk_lat);
        chk("frame_budget", f_budget, 0);
        chk("go_pulses", f_gocnt, 1);
        chk("accepted", f_sent, 4);
        chk("relu_in_at_go", f_snap, {f_in[3], f_in[2], f_in[1], f_in[0]});
        chk("relu_in_stable", f_stable, 1);
        for (int b = 0; b < 4; b++) chk($sformatf("beat%0d", b), f_got[b], exp[b*VW +: VW]);
        chk("m_last", f_lastok, 1);
        chk("m_hold", f_mhold, 1);
        chk("extra_beat", f_extra, 0);
        chk("no_err", err, 0);
        frames_model = frames_model + FCNT_W'(1);
        chk("frames_done", frames_done, frames_model);
        if (chk_lat) begin
            chk("lat_go", f_go, 4);
            chk("lat_mvalid", f_mv, 5 + lat);
            chk("lat_mlast", f_last, 8 + lat);
            chk("lat_sready", f_sready, 9 + lat);
        end
    endtask

    task automatic rand_inputs();
        logic [95:0] t;
        for (int n = 0; n < 4; n++) begin
            t = {$urandom, $urandom, $urandom};
            f_in[n] = t[VW-1:0];
        end
    endtask

    initial begin
        logic [15:0] fd_keep;
        logic [16*W-1:0] e;
        rst_n = 1'b0; relu_done = 1'b0; relu_out = '0; clr_err = 1'b0;
        bus.s_valid = 1'b0; bus.s_data = '0; bus.m_ready = 1'b1;

        tbl[0] = '{din: {pk4(0,0,-3,6), pk4(-8,-8,1,2), pk4(7,-2,4,9), pk4(-5,3,0,-1)},
                   dexp: {pk4(0,0,0,6), pk4(0,0,1,2), pk4(7,0,4,9), pk4(0,3,0,0)},
                   lat: 2, toggle: 0, stall_beat: -1, stall_len: 0, chk_lat: 1};
        tbl[1] = '{din: {pk4(-7,-7,-7,-7), pk4(100,-100,0,524288), pk4(1,-2,3,-4), pk4(-1048576,1048575,-1,1)},
                   dexp: {pk4(0,0,0,0), pk4(100,0,0,524288), pk4(1,0,3,0), pk4(0,1048575,0,1)},
                   lat: 1, toggle: 0, stall_beat: -1, stall_len: 0, chk_lat: 1};
        tbl[2] = '{din: {pk4(42,-42,13,-13), pk4(-3,3,-3,3), pk4(0,1,0,-1), pk4(10,-10,20,-20)},
                   dexp: {pk4(42,0,13,0), pk4(0,3,0,3), pk4(0,1,0,0), pk4(10,0,20,0)},
                   lat: 4, toggle: 1, stall_beat: 1, stall_len: 3, chk_lat: 0};

        // Outputs while held in reset, then idle state after release
        @(negedge clk);
        chk("rst_outputs", {bus.s_ready, relu_go, bus.m_valid, bus.m_last, busy, err}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_s_ready", bus.s_ready, 1);
        chk("idle_busy", busy, 0);
        chk("idle_frames", frames_done, 0);
        chk("idle_relu_in", relu_in, 0);

        // Table-driven frames
        for (int i = 0; i < 3; i++) begin
            for (int n = 0; n < 4; n++) f_in[n] = tbl[i].din[n*VW +: VW];
            run_frame(tbl[i].lat, tbl[i].toggle, tbl[i].stall_beat, tbl[i].stall_len, 0, -1);
            check_frame(tbl[i].dexp, tbl[i].lat, tbl[i].chk_lat);
        end

        // Spurious done while idle in FILL
        relu_done = 1'b1; relu_out = '1;
        repeat (3) @(negedge clk);
        chk("spur_idle_busy", busy, 0);
        chk("spur_idle_mvalid", bus.m_valid, 0);
        relu_done = 1'b0;

        // Spurious done during FILL and DRAIN of a real frame
        rand_inputs();
        run_frame(3, 0, -1, 0, 1, -1);
        e = relu16({f_in[3], f_in[2], f_in[1], f_in[0]});
        check_frame(e, 3, 1);

        // Done on the last watchdog cycle
        rand_inputs();
        run_frame(TIMEOUT, 0, -1, 0, 0, -1);
        e = relu16({f_in[3], f_in[2], f_in[1], f_in[0]});
        check_frame(e, TIMEOUT, 1);

        // Watchdog expiry and recovery
        rand_inputs();
        run_frame(-1, 0, -1, 0, 0, -1);
        chk("wd_err_cycle", f_err, f_go + TIMEOUT + 1);
        chk("wd_s_ready", bus.s_ready, 0);
        chk("wd_m_valid", bus.m_valid, 0);
        fd_keep = frames_done;
        relu_done = 1'b1;
        repeat (3) @(negedge clk);
        relu_done = 1'b0;
        chk("wd_sticky", err, 1);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        chk("clr_err", err, 0);
        chk("clr_s_ready", bus.s_ready, 1);
        chk("clr_busy", busy, 0);
        chk("clr_frames", frames_done, fd_keep);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        chk("clr_idle_ignored", bus.s_ready, 1);

        // Reset while waiting on the bank
        rand_inputs();
        run_frame(-1, 0, -1, 0, 0, 3);
        chk("mid_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_outputs", {bus.s_ready, relu_go, bus.m_valid, bus.m_last, busy, err}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        frames_model = '0;
        chk("mid_rst_frames", frames_done, 0);
        chk("mid_rst_relu_in", relu_in, 0);
        chk("mid_rst_busy", busy, 0);
        rand_inputs();
        run_frame(2, 0, -1, 0, 0, -1);
        e = relu16({f_in[3], f_in[2], f_in[1], f_in[0]});
        check_frame(e, 2, 1);

        // Randomised frames with stalls against the reference model
        for (int r = 0; r < 15; r++) begin
            int lat;
            lat = int'($urandom_range(1, 12));
            rand_inputs();
            run_frame(lat, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 4)), 0, -1);
            e = relu16({f_in[3], f_in[2], f_in[1], f_in[0]});
            check_frame(e, lat, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
